uart_burst_cmd_engine: RTL and testbench

Byte-level command engine between a UART receiver/transmitter pair and a word-wide on-chip memory. It parses a fixed header of one opcode byte plus ADDR_BYTES address bytes, then runs one of two bursts. A write burst assembles incoming bytes into words and writes BURST_WORDS words. A read burst fetches BURST_WORDS words and streams their bytes back out through the transmitter. It generalises the current single-purpose comms path in four ways: word width, burst length and address width are parameters; partial packets are recovered by a timeout; TX back-pressure is honoured; and bad opcodes are reported.

---
 rtl/uart_burst_cmd_engine.sv | 196 +++++++++++++++++++
 tb/tb_uart_burst_cmd_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_burst_cmd_engine.sv
// Byte-stream command engine: parses opcode + address header from a UART receiver,
// then runs a word-wide write burst into memory or a read burst streamed back out.
module uart_burst_cmd_engine #(
  parameter int         ADDR_BYTES     = 2,
  parameter int         ADDR_WIDTH     = 16,
  parameter int         WORD_BYTES     = 8,
  parameter int         BURST_WORDS    = 32,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] OP_WRITE       = 8'h00,
  parameter logic [7:0] OP_READ        = 8'h04
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rx_valid_in,
  input  logic [7:0]              rx_data_in,
  output logic [7:0]              tx_data_out,
  output logic                    tx_valid_out,
  input  logic                    tx_ready_in,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [8*WORD_BYTES-1:0] mem_wdata_out,
  output logic                    mem_we_out,
  output logic                    mem_re_out,
  input  logic [8*WORD_BYTES-1:0] mem_rdata_in,
  input  logic                    mem_rvalid_in,
  output logic                    busy_out,
  output logic                    error_out,
  output logic [7:0]              timeout_count_out
);
  localparam int AW8  = 8 * ADDR_BYTES;
  localparam int DW   = 8 * WORD_BYTES;
  localparam int CMAX = (WORD_BYTES > ADDR_BYTES) ? WORD_BYTES : ADDR_BYTES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WIW  = $clog2(BURST_WORDS + 1);
  localparam int TOW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0]  BYTE_LAST = CW'(WORD_BYTES - 1);
  localparam logic [WIW-1:0] WORD_LAST = WIW'(BURST_WORDS - 1);
  localparam logic [TOW-1:0] IDLE_LAST = TOW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RD_REQ, S_RD_WAIT, S_RD_SEND
  } state_t;

  state_t           state_r, state_s;
  logic             is_read_r, is_read_s;
  logic [AW8-1:0]   addr_r, addr_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIW-1:0]   word_idx_r, word_idx_s;
  logic [DW-1:0]    word_r, word_s;
  logic [TOW-1:0]   idle_r, idle_s;
  logic [7:0]       tcount_r, tcount_s;
  logic             error_r, error_s;
  logic             timeout_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // idle timer expires only while a header or write payload is half received
  assign timeout_s = (state_r == S_ADDR || state_r == S_WDATA) && !rx_valid_in
                     && (idle_r == IDLE_LAST);

  // next-state and datapath update; an arriving byte always clears the idle timer
  always_comb begin
    state_s    = state_r;
    is_read_s  = is_read_r;
    addr_s     = addr_r;
    cnt_s      = cnt_r;
    word_idx_s = word_idx_r;
    word_s     = word_r;
    idle_s     = '0;
    tcount_s   = tcount_r;
    error_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rx_valid_in && (rx_data_in == OP_WRITE || rx_data_in == OP_READ)) begin
          is_read_s  = (rx_data_in == OP_READ);
          cnt_s      = '0;
          word_idx_s = '0;
          state_s    = S_ADDR;
        end else if (rx_valid_in) begin
          error_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADDR: begin
        if (rx_valid_in) begin
          addr_s = (addr_r << 8) | AW8'(rx_data_in);
          if (cnt_r == ADDR_LAST) begin
            cnt_s   = '0;
            state_s = is_read_r ? S_RD_REQ : S_WDATA;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else if (timeout_s) begin
          state_s  = S_IDLE;
          error_s  = 1'b1;
          tcount_s = sat_inc(tcount_r);
        end else begin
          idle_s = idle_r + TOW'(1);
        end
      end
      S_WDATA: begin
        if (rx_valid_in) begin
          word_s = {rx_data_in, word_r[DW-1:8]};
          if (cnt_r == BYTE_LAST) begin
            cnt_s   = '0;
            state_s = S_WRITE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else if (timeout_s) begin
          state_s  = S_IDLE;
          error_s  = 1'b1;
          tcount_s = sat_inc(tcount_r);
        end else begin
          idle_s = idle_r + TOW'(1);
        end
      end
      S_WRITE: begin
        word_idx_s = word_idx_r + WIW'(1);
        if (word_idx_r == WORD_LAST) begin
          state_s = S_IDLE;
        end else if (rx_valid_in) begin
          // the write uses word_r this cycle, so the new byte can shift in behind it
          word_s  = {rx_data_in, word_r[DW-1:8]};
          cnt_s   = CW'(1);
          state_s = S_WDATA;
        end else begin
          state_s = S_WDATA;
        end
      end
      S_RD_REQ: state_s = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_rvalid_in) begin
          word_s  = mem_rdata_in;
          cnt_s   = '0;
          state_s = S_RD_SEND;
        end else begin
          state_s = S_RD_WAIT;
        end
      end
      S_RD_SEND: begin
        if (tx_ready_in) begin
          word_s = word_r >> 8;
          if (cnt_r == BYTE_LAST) begin
            cnt_s      = '0;
            word_idx_s = word_idx_r + WIW'(1);
            state_s    = (word_idx_r == WORD_LAST) ? S_IDLE : S_RD_REQ;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = S_RD_SEND;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= S_IDLE;
      is_read_r  <= 1'b0;
      addr_r     <= '0;
      cnt_r      <= '0;
      word_idx_r <= '0;
      word_r     <= '0;
      idle_r     <= '0;
      tcount_r   <= 8'h00;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      is_read_r  <= is_read_s;
      addr_r     <= addr_s;
      cnt_r      <= cnt_s;
      word_idx_r <= word_idx_s;
      word_r     <= word_s;
      idle_r     <= idle_s;
      tcount_r   <= tcount_s;
      error_r    <= error_s;
    end
  end

  assign mem_we_out        = (state_r == S_WRITE);
  assign mem_re_out        = (state_r == S_RD_REQ);
  assign tx_valid_out      = (state_r == S_RD_SEND);
  assign tx_data_out       = (state_r == S_RD_SEND) ? word_r[7:0] : 8'h00;
  assign mem_wdata_out     = word_r;
  assign mem_addr_out      = addr_r[ADDR_WIDTH-1:0] + ADDR_WIDTH'(word_idx_r);
  assign busy_out          = (state_r != S_IDLE);
  assign error_out         = error_r;
  assign timeout_count_out = tcount_r;
endmodule

// File: tb/tb_uart_burst_cmd_engine.sv
// Scoreboard bench for uart_burst_cmd_engine: stimulus pushes expected writes and
// tx bytes into queues, a negedge monitor pops and compares as the DUT produces them.
module tb_uart_burst_cmd_engine;
  localparam int TO = 1000;

  logic        clk_in = 1'b0;
  logic        rst_in, rx_valid_in, tx_ready_in, mem_rvalid_in;
  logic [7:0]  rx_data_in, tx_data_out, timeout_count_out;
  logic        tx_valid_out, mem_we_out, mem_re_out, busy_out, error_out;
  logic [15:0] mem_addr_out;
  logic [63:0] mem_wdata_out, mem_rdata_in;

  always #5 clk_in = ~clk_in;

  uart_burst_cmd_engine #(
    .ADDR_BYTES(2), .ADDR_WIDTH(16), .WORD_BYTES(8), .BURST_WORDS(32),
    .TIMEOUT_CYCLES(TO), .OP_WRITE(8'h00), .OP_READ(8'h04)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in),
    .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out), .mem_we_out(mem_we_out),
    .mem_re_out(mem_re_out), .mem_rdata_in(mem_rdata_in), .mem_rvalid_in(mem_rvalid_in),
    .busy_out(busy_out), .error_out(error_out), .timeout_count_out(timeout_count_out)
  );

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [63:0] mem [logic [15:0]];
  int tests_run = 0, tests_failed = 0;
  int cyc = 0, last_cyc = 0;
  int we_cnt = 0, re_cnt = 0, err_cnt = 0, tx_acc = 0, stall_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  logic [15:0] rd_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // byte k of word w for each stimulus pattern; below 256 means a constant fill
  function automatic logic [7:0] pat_byte(input int pat, input int w, input int k);
    if (pat < 256) return 8'(pat);
    else if (pat == 256) return 8'(w * 8 + k);
    else return 8'((w * 8 + k) ^ 8'hA5);
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // monitor: scoreboard pops, memory writes, pulse counters, back-pressure stability
  always @(negedge clk_in) begin : mon
    wr_t e;
    logic [7:0] b;
    if (mem_we_out) begin
      we_cnt++;
      mem[mem_addr_out] = mem_wdata_out;
      if (exp_wr.size() == 0) check("unexpected_write", 64'd1, 64'd0);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", 64'(mem_addr_out), 64'(e.addr));
        check("wr_data", mem_wdata_out, e.data);
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_re_out) re_cnt++;
    if (error_out) err_cnt++;
    if (stall_prev) begin
      check("stall_valid", 64'(tx_valid_out), 64'd1);
      check("stall_data", 64'(tx_data_out), 64'(stall_data));
    end
    if (tx_valid_out && tx_ready_in) begin
      tx_acc++;
      if (exp_tx.size() == 0) check("unexpected_tx", 64'd1, 64'd0);
      else begin
        b = exp_tx.pop_front();
        check("tx_byte", 64'(tx_data_out), 64'(b));
      end
    end
    if (tx_valid_out && !tx_ready_in) stall_cnt++;
    stall_prev = tx_valid_out && !tx_ready_in;
    stall_data = tx_data_out;
  end

  // memory read port: data returned two cycles after the request
  initial begin
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = 64'h0;
    forever begin
      @(negedge clk_in);
      if (mem_re_out) begin
        rd_addr = mem_addr_out;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        mem_rdata_in  = mem.exists(rd_addr) ? mem[rd_addr] : 64'h0;
        mem_rvalid_in = 1'b1;
        @(posedge clk_in);
        #1;
        mem_rvalid_in = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_in  = b;
    rx_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    rx_valid_in = 1'b0;
    last_cyc    = cyc;
  endtask

  task automatic write_burst(input logic [15:0] base, input int nbytes, input int pat, input int gap);
    logic [63:0] word;
    word = 64'h0;
    send_byte(8'h00);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    for (int i = 0; i < nbytes; i++) begin
      word[8*(i%8) +: 8] = pat_byte(pat, i / 8, i % 8);
      send_byte(pat_byte(pat, i / 8, i % 8));
      if (i % 8 == 7) exp_wr.push_back('{addr: 16'(base + 16'(i / 8)), data: word, cyc: last_cyc});
      if (i != nbytes - 1) step(gap);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4000 && busy_out; i++) step(1);
    check(name, 64'(busy_out), 64'd0);
  endtask

  task automatic read_burst(input logic [15:0] base, input int pat, input bit stall);
    int r0, a0, s0;
    r0 = re_cnt;
    s0 = stall_cnt;
    for (int w = 0; w < 32; w++)
      for (int k = 0; k < 8; k++) exp_tx.push_back(pat_byte(pat, w, k));
    send_byte(8'h04);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    if (stall) begin
      a0 = tx_acc;
      for (int i = 0; i < 200 && tx_acc < a0 + 3; i++) step(1);
      tx_ready_in = 1'b0;
      step(10);
      tx_ready_in = 1'b1;
      check("stall_cycles", 64'(stall_cnt - s0), 64'd10);
    end
    wait_idle("read_idle");
    check("read_re_count", 64'(re_cnt - r0), 64'd32);
    check("read_tx_left", 64'(exp_tx.size()), 64'd0);
  endtask

  initial begin : stim
    int e0, w0, r0;
    rst_in      = 1'b1;
    rx_valid_in = 1'b0;
    rx_data_in  = 8'h00;
    tx_ready_in = 1'b1;
    for (int w = 0; w < 32; w++) begin
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = pat_byte(257, w, k);
      mem[16'h2000 + 16'(w)] = v;
    end
    step(3);
    check("reset_ctrl", 64'({tx_valid_out, mem_we_out, mem_re_out, busy_out, error_out}), 64'd0);
    check("reset_data", 64'({mem_addr_out, tx_data_out, timeout_count_out}), 64'd0);
    check("reset_wdata", mem_wdata_out, 64'd0);
    rst_in = 1'b0;
    step(2);

    // full write burst, bytes back to back including during each write cycle
    e0 = err_cnt; w0 = we_cnt;
    write_burst(16'h0101, 256, 8'h01, 0);
    check("wr1_busy_last_write", 64'(busy_out), 64'd1);
    step(1);
    check("wr1_busy_after", 64'(busy_out), 64'd0);
    check("wr1_we_count", 64'(we_cnt - w0), 64'd32);
    check("wr1_no_error", 64'(err_cnt - e0), 64'd0);

    read_burst(16'h0101, 8'h01, 1'b0);

    // lost byte: 31 words land, then the idle timer recovers
    e0 = err_cnt; w0 = we_cnt;
    write_burst(16'h0300, 255, 8'h02, 0);
    step(TO - 2);
    check("to_not_early", 64'(err_cnt - e0), 64'd0);
    check("to_busy_waiting", 64'(busy_out), 64'd1);
    step(5);
    check("to_error_pulse", 64'(err_cnt - e0), 64'd1);
    check("to_count", 64'(timeout_count_out), 64'd1);
    check("to_idle", 64'(busy_out), 64'd0);
    check("to_we_count", 64'(we_cnt - w0), 64'd31);
    w0 = we_cnt;
    write_burst(16'h0300, 256, 8'h03, 0);
    wait_idle("to_retry_idle");
    check("to_retry_we_count", 64'(we_cnt - w0), 64'd32);

    read_burst(16'h2000, 257, 1'b1);

    // bad opcode: error only, no memory traffic
    e0 = err_cnt; w0 = we_cnt; r0 = re_cnt;
    send_byte(8'h55);
    step(3);
    check("badop_error", 64'(err_cnt - e0), 64'd1);
    check("badop_no_mem", 64'((we_cnt - w0) + (re_cnt - r0)), 64'd0);
    check("badop_idle", 64'(busy_out), 64'd0);
    check("badop_tcount", 64'(timeout_count_out), 64'd1);

    // address wrap past 0xFFFF, with a gap between bytes
    w0 = we_cnt;
    write_burst(16'hFFF0, 256, 256, 1);
    wait_idle("wrap_idle");
    check("wrap_we_count", 64'(we_cnt - w0), 64'd32);

    // reset in the middle of a write payload
    write_burst(16'h0500, 100, 8'h07, 0);
    rst_in = 1'b1;
    step(1);
    check("rst_mid_ctrl", 64'({tx_valid_out, mem_we_out, mem_re_out, busy_out, error_out}), 64'd0);
    check("rst_mid_data", 64'({mem_addr_out, tx_data_out, timeout_count_out}), 64'd0);
    check("rst_mid_wdata", mem_wdata_out, 64'd0);
    rst_in = 1'b0;
    w0 = we_cnt; r0 = re_cnt;
    step(20);
    check("rst_mid_no_mem", 64'((we_cnt - w0) + (re_cnt - r0)), 64'd0);
    check("rst_mid_wr_left", 64'(exp_wr.size()), 64'd0);

    read_burst(16'hFFF0, 256, 1'b0);
    check("final_wr_left", 64'(exp_wr.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
